// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared board geometry, solver state encoding and nibble access helpers
// for the sudoku solver controller.
package sudoku_pkg;
    localparam int NUM_CELLS = 81;
    localparam int CELL_W = 4;
    localparam int BOARD_W = 324;
    localparam logic [CELL_W-1:0] EMPTY = 4'd0;
    localparam logic [CELL_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [2:0] {IDLE, GCHK, SCAN, TRY, BACK, BCHK, OK, FAIL} state_t;

    function automatic logic [CELL_W-1:0] cell_get(input logic [BOARD_W-1:0] board, input logic [6:0] k);
        return board[{k, 2'b00} +: CELL_W];
    endfunction

    function automatic logic [BOARD_W-1:0] cell_set(input logic [BOARD_W-1:0] board, input logic [6:0] k,
                                                    input logic [CELL_W-1:0] v);
        logic [BOARD_W-1:0] b;
        b = board;
        b[{k, 2'b00} +: CELL_W] = v;
        return b;
    endfunction
endpackage

// File: rtl/sudoku_solver_fsm.sv
// sudoku_solver_fsm: validates the givens, then runs a cell-ordered backtracking search,
// querying an external combinational checker one candidate per cycle.
module sudoku_solver_fsm
    import sudoku_pkg::*;
#(
    parameter logic [31:0] MAX_CYCLES = 32'd10_000_000,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    output logic [BOARD_W-1:0] board_out,
    output logic               busy,
    output logic               done,
    output logic               solved,
    output logic               timeout,
    output logic [CNT_W-1:0]   cycles,
    output logic [CELL_W-1:0]  chk_num,
    output logic [6:0]         chk_cell,
    output logic [BOARD_W-1:0] chk_board,
    input  logic               chk_valid
);
    localparam logic [6:0] END_IDX = 7'(NUM_CELLS);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 32'd1);

    state_t state, state_n;
    logic [BOARD_W-1:0] board, board_n;
    logic [NUM_CELLS-1:0] given, given_n;
    logic [6:0] idx, idx_n;
    logic [CELL_W-1:0] cand, cand_n, cur;
    logic busy_n, done_n, solved_n, timeout_n;
    logic [CNT_W-1:0] cycles_n;

    assign cur = cell_get(board, idx);
    assign board_out = board;
    assign chk_board = board;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            board <= '0;
            given <= '0;
            idx <= '0;
            cand <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            solved <= 1'b0;
            timeout <= 1'b0;
            cycles <= '0;
        end else begin
            state <= state_n;
            board <= board_n;
            given <= given_n;
            idx <= idx_n;
            cand <= cand_n;
            busy <= busy_n;
            done <= done_n;
            solved <= solved_n;
            timeout <= timeout_n;
            cycles <= cycles_n;
        end
    end

    always_comb begin
        state_n = state;
        board_n = board;
        given_n = given;
        idx_n = idx;
        cand_n = cand;
        busy_n = busy;
        done_n = done;
        solved_n = solved;
        timeout_n = timeout;
        cycles_n = busy ? cycles + CNT_W'(1) : cycles;
        chk_num = EMPTY;
        chk_cell = '0;
        case (state)
            IDLE: if (start) begin
                board_n = board_in;
                for (int k = 0; k < NUM_CELLS; k++) given_n[k] = cell_get(board_in, 7'(k)) != EMPTY;
                idx_n = '0;
                cycles_n = '0;
                done_n = 1'b0;
                solved_n = 1'b0;
                timeout_n = 1'b0;
                busy_n = 1'b1;
                state_n = GCHK;
            end
            GCHK: if (idx == END_IDX) begin
                idx_n = '0;
                state_n = SCAN;
            end else if (!given[idx]) begin
                idx_n = idx + 7'd1;
            end else begin
                chk_num = cur;
                chk_cell = idx;
                state_n = chk_valid ? GCHK : FAIL;
                idx_n = chk_valid ? idx + 7'd1 : idx;
            end
            SCAN: if (idx == END_IDX) begin
                state_n = OK;
            end else if (given[idx]) begin
                idx_n = idx + 7'd1;
            end else begin
                cand_n = cur + 4'd1;
                state_n = TRY;
            end
            TRY: if (cand == MAX_DIGIT + 4'd1) begin
                board_n = cell_set(board, idx, EMPTY);
                state_n = BACK;
            end else begin
                chk_num = cand;
                chk_cell = idx;
                if (chk_valid) begin
                    board_n = cell_set(board, idx, cand);
                    idx_n = idx + 7'd1;
                    state_n = SCAN;
                end else begin
                    cand_n = cand + 4'd1;
                end
            end
            BACK: begin
                state_n = idx == '0 ? FAIL : BCHK;
                idx_n = idx == '0 ? idx : idx - 7'd1;
            end
            BCHK: if (given[idx]) begin
                state_n = BACK;
            end else begin
                cand_n = cur + 4'd1;
                state_n = TRY;
            end
            OK, FAIL: begin
                done_n = 1'b1;
                solved_n = state == OK;
                busy_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Budget exhaustion overrides the search step; the partial board and count are frozen.
        if (MAX_CYCLES != 0 && state inside {GCHK, SCAN, TRY, BACK, BCHK} && cycles == LAST_CYCLE) begin
            state_n = IDLE;
            board_n = board;
            done_n = 1'b1;
            timeout_n = 1'b1;
            solved_n = 1'b0;
            busy_n = 1'b0;
            cycles_n = cycles;
        end
    end
endmodule
